// File: rtl/cpu_pkg.sv
// Shared widths and opcode encodings for the 8-bit accumulator CPU.
// Consumed by the datapath, its ALU and the controller.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 2;
    localparam int ADR_W  = DATA_W - OP_W;

    typedef enum logic [OP_W-1:0] {
        OP_LDA = 2'b00,
        OP_ADD = 2'b01,
        OP_STA = 2'b10,
        OP_JMP = 2'b11
    } opcode_e;

endpackage

// File: rtl/acc_cpu_datapath_if.sv
// Controller/memory <-> datapath signal bundle; acZero exists only with ACC_ZERO_FLAG_EN.
// Purely wiring: no storage, no flow control (strobes are single-cycle commands).
interface acc_cpu_datapath_if
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADR_W,
    parameter int OW = OP_W
);
    logic          pass;
    logic          add;
    logic          ldAc;
    logic          ldIr;
    logic          incPc;
    logic          ldPc;
    logic          irOnAdr;
    logic          pcOnAdr;
    logic [DW-1:0] dataBusIn;
    logic [DW-1:0] dataBusOut;
    logic [AW-1:0] adrBus;
    logic [OW-1:0] opcode;
`ifdef ACC_ZERO_FLAG_EN
    logic          acZero;
`endif

    modport master (
        output pass, add, ldAc, ldIr, incPc, ldPc, irOnAdr, pcOnAdr, dataBusIn,
`ifdef ACC_ZERO_FLAG_EN
        input  acZero,
`endif
        input  dataBusOut, adrBus, opcode
    );

    modport slave (
        input  pass, add, ldAc, ldIr, incPc, ldPc, irOnAdr, pcOnAdr, dataBusIn,
`ifdef ACC_ZERO_FLAG_EN
        output acZero,
`endif
        output dataBusOut, adrBus, opcode
    );

endinterface

// File: rtl/acc_alu.sv
// Combinational pass/add unit: add (priority) gives a+b mod 2^DATA_W, otherwise passes b.
// Zero latency; no backpressure.
module acc_alu
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         pass,
    input  logic         add,
    output logic [W-1:0] result
);

    always_comb begin
        result = b;
        if (add) begin
            result = a + b;  // carry intentionally dropped
        end else if (pass) begin
            result = b;
        end
    end

endmodule

// File: rtl/acc_cpu_datapath.sv
// AC/IR/PC registers, ALU and address mux of the accumulator CPU; optional acZero via ACC_ZERO_FLAG_EN.
// Loads visible one cycle after the strobe edge, adrBus is combinational; no backpressure.
module acc_cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADR_W,
    parameter int OW = OP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    acc_cpu_datapath_if.slave   bus
);

    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] alu_result;

    acc_alu #(.W(DW)) u_alu (
        .a      (ac_q),
        .b      (bus.dataBusIn),
        .pass   (bus.pass),
        .add    (bus.add),
        .result (alu_result)
    );

    always_comb begin
        ac_d = ac_q;
        ir_d = ir_q;
        pc_d = pc_q;
        if (bus.ldAc) begin
            ac_d = alu_result;
        end
        if (bus.ldIr) begin
            ir_d = bus.dataBusIn;
        end
        // Jump target comes from the pre-edge IR, even if IR reloads on this edge.
        if (bus.ldPc) begin
            pc_d = ir_q[AW-1:0];
        end else if (bus.incPc) begin
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q <= '0;
            ir_q <= '0;
            pc_q <= '0;
        end else begin
            ac_q <= ac_d;
            ir_q <= ir_d;
            pc_q <= pc_d;
        end
    end

    always_comb begin
        bus.adrBus = '0;
        if (bus.irOnAdr) begin
            bus.adrBus = ir_q[AW-1:0];
        end else if (bus.pcOnAdr) begin
            bus.adrBus = pc_q;
        end
    end

    assign bus.dataBusOut = ac_q;
    assign bus.opcode     = ir_q[DW-1 -: OW];

`ifdef ACC_ZERO_FLAG_EN
    assign bus.acZero = (ac_q == '0);
`endif

endmodule

// File: tb/tb_acc_cpu_datapath.sv
// Directed bench for acc_cpu_datapath with hand-computed expected values.
module tb_acc_cpu_datapath;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    acc_cpu_datapath_if dp_if ();

    acc_cpu_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dp_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dp_if.pass      = 1'b0;
        dp_if.add       = 1'b0;
        dp_if.ldAc      = 1'b0;
        dp_if.ldIr      = 1'b0;
        dp_if.incPc     = 1'b0;
        dp_if.ldPc      = 1'b0;
        dp_if.irOnAdr   = 1'b0;
        dp_if.pcOnAdr   = 1'b0;
        dp_if.dataBusIn = 8'd0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic exp);
`ifdef ACC_ZERO_FLAG_EN
        chk(tag, {7'd0, dp_if.acZero}, {7'd0, exp});
`else
        if (exp === 1'bx) $display("%s", tag);
`endif
    endtask

    initial begin
        idle();
        #2;
        // Random strobes held during reset must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            {dp_if.pass, dp_if.add, dp_if.ldAc, dp_if.ldIr,
             dp_if.incPc, dp_if.ldPc, dp_if.irOnAdr, dp_if.pcOnAdr} = 8'($urandom);
            dp_if.dataBusIn = 8'($urandom_range(1, 255));
            tick();
            chk("rst_dout", dp_if.dataBusOut, 8'd0);
            chk("rst_adr", {2'd0, dp_if.adrBus}, 8'd0);
            chk("rst_op", {6'd0, dp_if.opcode}, 8'd0);
        end
        chk_zero("rst_zero", 1'b1);
        idle();
        #3 rst_n = 1'b1;

        // IR load and address mux
        dp_if.dataBusIn = 8'd212;
        dp_if.ldIr = 1'b1;
        tick();
        dp_if.ldIr = 1'b0;
        chk("ir_opcode", {6'd0, dp_if.opcode}, 8'd3);
        dp_if.irOnAdr = 1'b1;
        #1 chk("ir_on_adr", {2'd0, dp_if.adrBus}, 8'd20);
        dp_if.pcOnAdr = 1'b1;
        #1 chk("ir_pri_adr", {2'd0, dp_if.adrBus}, 8'd20);
        dp_if.irOnAdr = 1'b0;
        #1 chk("pc_on_adr", {2'd0, dp_if.adrBus}, 8'd0);
        dp_if.pcOnAdr = 1'b0;

        // AC load / add
        dp_if.dataBusIn = 8'd10;
        dp_if.pass = 1'b1;
        dp_if.ldAc = 1'b1;
        tick();
        chk("ac_load10", dp_if.dataBusOut, 8'd10);
        chk_zero("ac_nonzero", 1'b0);
        dp_if.pass = 1'b0;
        dp_if.ldAc = 1'b0;
        dp_if.add = 1'b1;
        dp_if.dataBusIn = 8'd5;
        tick();
        chk("ac_hold_noload", dp_if.dataBusOut, 8'd10);
        dp_if.ldAc = 1'b1;
        tick();
        chk("ac_add15", dp_if.dataBusOut, 8'd15);
        dp_if.add = 1'b0;
        dp_if.pass = 1'b1;
        dp_if.dataBusIn = 8'd200;
        tick();
        chk("ac_load200", dp_if.dataBusOut, 8'd200);
        dp_if.pass = 1'b0;
        dp_if.add = 1'b1;
        dp_if.dataBusIn = 8'd100;
        tick();
        chk("ac_add_wrap", dp_if.dataBusOut, 8'd44);
        dp_if.pass = 1'b1;
        dp_if.dataBusIn = 8'd6;
        tick();
        chk("ac_add_pri", dp_if.dataBusOut, 8'd50);
        dp_if.pass = 1'b0;
        dp_if.add = 1'b0;
        dp_if.dataBusIn = 8'd7;
        tick();
        chk("ac_nosel_pass", dp_if.dataBusOut, 8'd7);
        idle();

        // ldPc priority and old-IR semantics (IR still 212 -> field 20)
        dp_if.ldPc = 1'b1;
        dp_if.incPc = 1'b1;
        tick();
        idle();
        dp_if.pcOnAdr = 1'b1;
        #1 chk("ldpc_pri", {2'd0, dp_if.adrBus}, 8'd20);
        dp_if.incPc = 1'b1;
        tick();
        dp_if.incPc = 1'b0;
        chk("pc_inc21", {2'd0, dp_if.adrBus}, 8'd21);
        dp_if.ldIr = 1'b1;
        dp_if.ldPc = 1'b1;
        dp_if.dataBusIn = 8'h3F;
        tick();
        dp_if.ldIr = 1'b0;
        dp_if.ldPc = 1'b0;
        chk("ldpc_old_ir", {2'd0, dp_if.adrBus}, 8'd20);
        chk("new_ir_op", {6'd0, dp_if.opcode}, 8'd0);
        dp_if.ldPc = 1'b1;
        tick();
        dp_if.ldPc = 1'b0;
        chk("pc_preset63", {2'd0, dp_if.adrBus}, 8'd63);
        dp_if.incPc = 1'b1;
        tick();
        dp_if.incPc = 1'b0;
        chk("pc_wrap", {2'd0, dp_if.adrBus}, 8'd0);
        dp_if.pcOnAdr = 1'b0;
        dp_if.irOnAdr = 1'b0;
        #1 chk("no_select", {2'd0, dp_if.adrBus}, 8'd0);

        // Asynchronous reset mid-cycle, then PC count from zero
        dp_if.pass = 1'b1;
        dp_if.ldAc = 1'b1;
        dp_if.dataBusIn = 8'd77;
        tick();
        chk("ac_pre_rst", dp_if.dataBusOut, 8'd77);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", dp_if.dataBusOut, 8'd0);
        chk_zero("async_zero", 1'b1);
        dp_if.dataBusIn = 8'd99;
        tick();
        chk("rst_ignore_ld", dp_if.dataBusOut, 8'd0);
        idle();
        #2 rst_n = 1'b1;
        dp_if.incPc = 1'b1;
        dp_if.pcOnAdr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("pc_count%0d", i), {2'd0, dp_if.adrBus}, 8'(i));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
